// File: rtl/noc_pkg.sv
// Shared types and helpers for the XY mesh router.
// Coordinates travel through the helpers as a fixed-width coord_t, wide
// enough for any supported mesh. Each module casts its own CW-bit
// coordinates to coord_t before calling the helpers.
package noc_pkg;

  localparam int COORD_MAX_W = 8;

  typedef logic [COORD_MAX_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOP   = 2'd1,
    DELIV = 2'd2
  } state_e;

  // Flat node number; nodes are numbered column-major (x*MESH_Y + y).
  function automatic int node_idx(input coord_t x, input coord_t y, input int mesh_y);
    return int'(x) * mesh_y + int'(y);
  endfunction

  // True when (x,y) lies inside a mesh_x by mesh_y mesh.
  function automatic logic in_range(input coord_t x, input coord_t y,
                                    input int mesh_x, input int mesh_y);
    return (int'(x) < mesh_x) && (int'(y) < mesh_y);
  endfunction

endpackage

// File: rtl/noc_xy_step.sv
// One XY dimension-order routing step. X is corrected first, then Y.
// The caller range-checks coordinates beforehand, so a step can never wrap.
module noc_xy_step
  import noc_pkg::*;
#(
  parameter int CW = 2
) (
  input  logic [CW-1:0] cur_x_i,
  input  logic [CW-1:0] cur_y_i,
  input  logic [CW-1:0] dst_x_i,
  input  logic [CW-1:0] dst_y_i,
  output logic [CW-1:0] nxt_x_o,
  output logic [CW-1:0] nxt_y_o,
  output logic          arrived_o
);

  assign arrived_o = (cur_x_i == dst_x_i) && (cur_y_i == dst_y_i);

  // Move one hop: along x until it matches, then along y.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    nxt_x_o = cur_x_i;
    nxt_y_o = cur_y_i;
    if (cur_x_i != dst_x_i) begin
      nxt_x_o = (cur_x_i < dst_x_i) ? cur_x_i + 1'b1 : cur_x_i - 1'b1;
    end else if (cur_y_i != dst_y_i) begin
      nxt_y_o = (cur_y_i < dst_y_i) ? cur_y_i + 1'b1 : cur_y_i - 1'b1;
    end
  end

endmodule

// File: rtl/noc_mesh_xy_router.sv
// Clocked MESH_X x MESH_Y XY router. It carries one packet at a time, one hop per
// cycle, into per-node holding registers. Each node hands its packet over with
// an ack handshake.
// Optional feature macro: NOC_HOPCNT_EN adds the out_hops port and the hop counter.
module noc_mesh_xy_router
  import noc_pkg::*;
#(
  parameter int  MESH_X    = 4,
  parameter int  MESH_Y    = 4,
  parameter int  PAYLOAD_W = 2,
  localparam int CW        = $clog2((MESH_X > MESH_Y) ? MESH_X : MESH_Y),
  localparam int N         = MESH_X * MESH_Y
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CW-1:0]          src_x,
  input  logic [CW-1:0]          src_y,
  input  logic [CW-1:0]          dest_x,
  input  logic [CW-1:0]          dest_y,
  input  logic [PAYLOAD_W-1:0]   payload,
  output logic [N*PAYLOAD_W-1:0] out_data,
  output logic [N-1:0]           out_valid,
  input  logic [N-1:0]           out_ack,
  output logic                   err_drop
`ifdef NOC_HOPCNT_EN
  ,
  output logic [MESH_X*MESH_Y*$clog2(MESH_X+MESH_Y-1)-1:0] out_hops
`endif
);

`ifdef NOC_HOPCNT_EN
  localparam int HW = $clog2(MESH_X + MESH_Y - 1);
`endif

  state_e                 state_q, state_d;
  logic [CW-1:0]          cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [CW-1:0]          dst_x_q, dst_x_d, dst_y_q, dst_y_d;
  logic [PAYLOAD_W-1:0]   pay_q, pay_d;
  logic [N-1:0]           out_valid_q, out_valid_d;
  logic [N*PAYLOAD_W-1:0] out_data_q, out_data_d;
  logic                   err_q, err_d;
`ifdef NOC_HOPCNT_EN
  logic [HW-1:0]          hops_q, hops_d;
  logic [N*HW-1:0]        out_hops_q, out_hops_d;
`endif

  logic [CW-1:0] nxt_x, nxt_y;
  logic          arrived;
  logic [N-1:0]  dst_sel;
  logic          deliv_ok;

  noc_xy_step #(.CW(CW)) u_step (
    .cur_x_i   (cur_x_q),
    .cur_y_i   (cur_y_q),
    .dst_x_i   (dst_x_q),
    .dst_y_i   (dst_y_q),
    .nxt_x_o   (nxt_x),
    .nxt_y_o   (nxt_y),
    .arrived_o (arrived)
  );

  // One-hot select of the destination node's holding register.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      dst_sel[i] = (node_idx(coord_t'(dst_x_q), coord_t'(dst_y_q), MESH_Y) == i);
    end
  end

  // The destination register is free when it is empty or being acked this cycle.
  assign deliv_ok = |(dst_sel & (~out_valid_q | out_ack));

  // Next-state, datapath and per-node register updates.
  always_comb begin
    state_d     = state_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    dst_x_d     = dst_x_q;
    dst_y_d     = dst_y_q;
    pay_d       = pay_q;
    err_d       = 1'b0;
    out_valid_d = out_valid_q & ~out_ack;
    out_data_d  = out_data_q;
`ifdef NOC_HOPCNT_EN
    hops_d      = hops_q;
    out_hops_d  = out_hops_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!(in_range(coord_t'(src_x), coord_t'(src_y), MESH_X, MESH_Y) &&
                in_range(coord_t'(dest_x), coord_t'(dest_y), MESH_X, MESH_Y))) begin
            err_d = 1'b1;
          end else begin
            cur_x_d = src_x;
            cur_y_d = src_y;
            dst_x_d = dest_x;
            dst_y_d = dest_y;
            pay_d   = payload;
`ifdef NOC_HOPCNT_EN
            hops_d  = '0;
`endif
            state_d = HOP;
          end
        end
      end
      HOP: begin
        if (arrived) begin
          state_d = DELIV;
        end else begin
          cur_x_d = nxt_x;
          cur_y_d = nxt_y;
`ifdef NOC_HOPCNT_EN
          hops_d  = hops_q + 1'b1;
`endif
        end
      end
      DELIV: begin
        // A delivery overrides a same-cycle ack on the destination node.
        if (deliv_ok) begin
          for (int i = 0; i < N; i++) begin
            if (dst_sel[i]) begin
              out_valid_d[i]                       = 1'b1;
              out_data_d[i*PAYLOAD_W +: PAYLOAD_W] = pay_q;
`ifdef NOC_HOPCNT_EN
              out_hops_d[i*HW +: HW]               = hops_q;
`endif
            end
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q     <= IDLE;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      pay_q       <= '0;
      out_valid_q <= '0;
      // NOTE: the holding registers are visible outputs, so they are reset too (not left as uninitialised storage).
      out_data_q  <= '0;
      err_q       <= 1'b0;
`ifdef NOC_HOPCNT_EN
      hops_q      <= '0;
      out_hops_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      dst_x_q     <= dst_x_d;
      dst_y_q     <= dst_y_d;
      pay_q       <= pay_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
`ifdef NOC_HOPCNT_EN
      hops_q      <= hops_d;
      out_hops_q  <= out_hops_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err_drop  = err_q;
`ifdef NOC_HOPCNT_EN
  assign out_hops  = out_hops_q;
`endif

endmodule

// File: tb/tb_noc_mesh_xy_router.sv
// Directed bench for noc_mesh_xy_router. It drives a 4x4 instance for routing,
// stall and reset scenarios, and a 3x5 instance for range-check drops.
// When NOC_HOPCNT_EN is defined, it also checks out_hops.
module tb_noc_mesh_xy_router;

  logic clk;
  logic rst_n;

  // 4x4 instance
  logic        a_in_valid, a_in_ready;
  logic [1:0]  a_src_x, a_src_y, a_dest_x, a_dest_y;
  logic [1:0]  a_payload;
  logic [31:0] a_out_data;
  logic [15:0] a_out_valid, a_out_ack;
  logic        a_err_drop;
`ifdef NOC_HOPCNT_EN
  logic [47:0] a_out_hops;
  logic [44:0] b_out_hops;
`endif

  // 3x5 instance
  logic        b_in_valid, b_in_ready;
  logic [2:0]  b_src_x, b_src_y, b_dest_x, b_dest_y;
  logic [1:0]  b_payload;
  logic [29:0] b_out_data;
  logic [14:0] b_out_valid, b_out_ack;
  logic        b_err_drop;

  int errors = 0;
  int checks = 0;

  noc_mesh_xy_router #(.MESH_X(4), .MESH_Y(4), .PAYLOAD_W(2)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .src_x     (a_src_x),
    .src_y     (a_src_y),
    .dest_x    (a_dest_x),
    .dest_y    (a_dest_y),
    .payload   (a_payload),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_ack   (a_out_ack),
    .err_drop  (a_err_drop)
`ifdef NOC_HOPCNT_EN
    ,
    .out_hops  (a_out_hops)
`endif
  );

  noc_mesh_xy_router #(.MESH_X(3), .MESH_Y(5), .PAYLOAD_W(2)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .src_x     (b_src_x),
    .src_y     (b_src_y),
    .dest_x    (b_dest_x),
    .dest_y    (b_dest_y),
    .payload   (b_payload),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ack   (b_out_ack),
    .err_drop  (b_err_drop)
`ifdef NOC_HOPCNT_EN
    ,
    .out_hops  (b_out_hops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_a(input logic [1:0] sx, sy, dx, dy, input logic [1:0] pay);
    a_in_valid = 1'b1;
    a_src_x = sx; a_src_y = sy; a_dest_x = dx; a_dest_y = dy;
    a_payload = pay;
  endtask

  task automatic drive_b(input logic [2:0] sx, sy, dx, dy, input logic [1:0] pay);
    b_in_valid = 1'b1;
    b_src_x = sx; b_src_y = sy; b_dest_x = dx; b_dest_y = dy;
    b_payload = pay;
  endtask

  function automatic logic [1:0] a_slot(input int idx);
    logic [31:0] d;
    d = a_out_data;
    return d[idx*2 +: 2];
  endfunction

  function automatic logic [1:0] b_slot(input int idx);
    logic [29:0] d;
    d = b_out_data;
    return d[idx*2 +: 2];
  endfunction

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_src_x = '0; a_src_y = '0; a_dest_x = '0; a_dest_y = '0;
    a_payload = '0; a_out_ack = '0;
    b_in_valid = 1'b0; b_src_x = '0; b_src_y = '0; b_dest_x = '0; b_dest_y = '0;
    b_payload = '0; b_out_ack = '0;

    // Reset state
    cyc(); cyc();
    check("rst_ready",  64'(a_in_ready),  64'd1);
    check("rst_valid",  64'(a_out_valid), 64'd0);
    check("rst_data",   64'(a_out_data),  64'd0);
    check("rst_err",    64'(a_err_drop),  64'd0);
    check("rst_b_valid", 64'(b_out_valid), 64'd0);
    rst_n = 1'b1;
    cyc();

    // (0,0)->(3,3) payload 2'b10: D=6, delivery after edge 8 into node 15
    drive_a(2'd0, 2'd0, 2'd3, 2'd3, 2'b10);
    cyc();
    a_in_valid = 1'b0;
    check("t1_ready_e0", 64'(a_in_ready), 64'd0);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      check("t1_ready_busy", 64'(a_in_ready),  64'd0);
      check("t1_valid_busy", 64'(a_out_valid), 64'd0);
    end
    cyc();
    check("t1_valid",  64'(a_out_valid), 64'h8000);
    check("t1_data",   64'(a_out_data),  64'h8000_0000);
    check("t1_ready",  64'(a_in_ready),  64'd1);
    a_out_ack = 16'h8000;
    cyc();
    a_out_ack = '0;
    check("t1_ack_valid", 64'(a_out_valid), 64'h0000);
    check("t1_ack_data",  64'(a_slot(15)),  64'd2);

    // (3,0)->(0,2) payload 3: D=5, node 2 after edge 7, hop count 5
    drive_a(2'd3, 2'd0, 2'd0, 2'd2, 2'b11);
    cyc();
    a_in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) cyc();
    check("hop_valid_e6", 64'(a_out_valid), 64'h0000);
    cyc();
    check("hop_valid_e7", 64'(a_out_valid), 64'h0004);
    check("hop_data",     64'(a_slot(2)),   64'd3);
`ifdef NOC_HOPCNT_EN
    check("hop_count",    64'(a_out_hops[2*3 +: 3]), 64'd5);
`endif

    // src==dest=(2,1) payload 1: node 9 after edge 2
    drive_a(2'd2, 2'd1, 2'd2, 2'd1, 2'b01);
    cyc();
    a_in_valid = 1'b0;
    check("t2_ready_e0", 64'(a_in_ready), 64'd0);
    cyc();
    check("t2_valid_e1", 64'(a_out_valid), 64'h0004);
    cyc();
    check("t2_valid_e2", 64'(a_out_valid), 64'h0204);
    check("t2_data",     64'(a_slot(9)),   64'd1);
    check("t2_ready",    64'(a_in_ready),  64'd1);
    a_out_ack = 16'h0200;
    cyc();
    a_out_ack = '0;
    check("t2_ack", 64'(a_out_valid), 64'h0004);

    // Two packets to (1,2) = node 6 with no ack in between: second stalls
    drive_a(2'd0, 2'd0, 2'd1, 2'd2, 2'b11);
    cyc();
    a_in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) cyc();
    check("t3_first_valid", 64'(a_out_valid), 64'h0044);
    check("t3_first_data",  64'(a_slot(6)),   64'd3);
    drive_a(2'd1, 2'd1, 2'd1, 2'd2, 2'b10);
    cyc();
    a_in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("t3_stall_ready", 64'(a_in_ready), 64'd0);
    end
    check("t3_stall_valid", 64'(a_out_valid), 64'h0044);
    check("t3_stall_data",  64'(a_slot(6)),   64'd3);
    a_out_ack = 16'h0040;
    cyc();
    a_out_ack = '0;
    check("t3_load_valid", 64'(a_out_valid), 64'h0044);
    check("t3_load_data",  64'(a_slot(6)),   64'd2);
    check("t3_load_ready", 64'(a_in_ready),  64'd1);
    a_out_ack = 16'h0040;
    cyc();
    a_out_ack = '0;
    check("t3_ack", 64'(a_out_valid), 64'h0004);

    // Ack on an empty node is ignored
    a_out_ack = 16'h0001;
    cyc();
    a_out_ack = '0;
    check("idle_ack", 64'(a_out_valid), 64'h0004);

    // 3x5 mesh: dest_x=3 out of range -> one-cycle err_drop, no delivery
    drive_b(3'd0, 3'd0, 3'd3, 3'd0, 2'b01);
    cyc();
    b_in_valid = 1'b0;
    check("drop_err",   64'(b_err_drop),  64'd1);
    check("drop_ready", 64'(b_in_ready),  64'd1);
    check("drop_valid", 64'(b_out_valid), 64'd0);
    cyc();
    check("drop_err_end", 64'(b_err_drop), 64'd0);
    // dest_y=5 is also out of range
    drive_b(3'd0, 3'd0, 3'd0, 3'd5, 2'b01);
    cyc();
    b_in_valid = 1'b0;
    check("drop_y_err", 64'(b_err_drop), 64'd1);
    cyc();
    // (0,0)->(2,4) payload 1 on 3x5: node 14, D=6, after edge 8
    drive_b(3'd0, 3'd0, 3'd2, 3'd4, 2'b01);
    cyc();
    b_in_valid = 1'b0;
    for (int k = 1; k <= 7; k++) cyc();
    check("b_valid_e7", 64'(b_out_valid), 64'h0000);
    cyc();
    check("b_valid_e8", 64'(b_out_valid), 64'h4000);
    check("b_data",     64'(b_slot(14)),  64'd1);

    // Reset during HOP on (0,0)->(3,0): nothing is ever delivered
    drive_a(2'd0, 2'd0, 2'd3, 2'd0, 2'b11);
    cyc();
    a_in_valid = 1'b0;
    cyc();
    rst_n = 1'b0;
    cyc();
    check("mid_rst_ready", 64'(a_in_ready),  64'd1);
    check("mid_rst_valid", 64'(a_out_valid), 64'd0);
    check("mid_rst_data",  64'(a_out_data),  64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) cyc();
    check("mid_rst_never", 64'(a_out_valid), 64'd0);
`ifdef NOC_HOPCNT_EN
    check("mid_rst_hops",  64'(a_out_hops),  64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
